// File: rtl/spi_master_tx_cs.sv
// Transmit-only SPI master with configurable word width, bit order, SPI mode,
// chip-select setup/hold/idle timing and multi-word bursts under one CS frame.
module spi_master_tx_cs #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned SPI_MODE          = 0,
  parameter int unsigned CLKS_PER_HALF_BIT = 2,
  parameter int unsigned LSB_FIRST         = 0,
  parameter int unsigned CS_SETUP_CLKS     = 2,
  parameter int unsigned CS_HOLD_CLKS      = 2,
  parameter int unsigned CS_IDLE_CLKS      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  input  logic                  data_last_i,
  output logic                  data_ready_o,
  output logic                  busy_o,
  output logic                  spi_clk_o,
  output logic                  spi_mosi_o,
  output logic                  spi_cs_n_o
);

  localparam logic        CPOL   = 1'((SPI_MODE >> 1) & 32'd1);
  localparam logic        CPHA   = 1'(SPI_MODE & 32'd1);
  localparam int unsigned HALF_W = $clog2(CLKS_PER_HALF_BIT);
  localparam int unsigned EDGES  = 2 * DATA_WIDTH;
  localparam int unsigned EDGE_W = $clog2(EDGES);
  localparam int unsigned CNT_MAX_SH = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int unsigned CNT_MAX = (CNT_MAX_SH > CS_IDLE_CLKS) ? CNT_MAX_SH : CS_IDLE_CLKS;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;

  state_t                state;
  logic [HALF_W-1:0]     half_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [CNT_W-1:0]      tmr;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  last_q;

  logic accept_c;
  logic half_end_c;
  logic word_end_c;
  logic pre_end_c;

  // Bit that goes on the wire first for a given word
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_WIDTH-1];
  endfunction

  // Word with its outgoing bit removed
  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  // Handshake and half-bit position decode
  assign accept_c   = data_valid_i & data_ready_o;
  assign half_end_c = (half_cnt == HALF_W'(CLKS_PER_HALF_BIT - 1));
  assign word_end_c = half_end_c && (edge_cnt == EDGE_W'(EDGES - 1));
  assign pre_end_c  = (half_cnt == HALF_W'(CLKS_PER_HALF_BIT - 2)) &&
                      (edge_cnt == EDGE_W'(EDGES - 1));

  // Frame FSM, counters, shift register and registered SPI outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      half_cnt     <= '0;
      edge_cnt     <= '0;
      tmr          <= '0;
      shreg        <= '0;
      last_q       <= 1'b0;
      data_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      spi_clk_o    <= CPOL;
      spi_mosi_o   <= 1'b0;
      spi_cs_n_o   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          data_ready_o <= 1'b1;
          if (accept_c) begin
            state        <= SETUP;
            data_ready_o <= 1'b0;
            busy_o       <= 1'b1;
            spi_cs_n_o   <= 1'b0;
            tmr          <= '0;
            last_q       <= data_last_i;
            shreg        <= CPHA ? data_i : shift_out(data_i);
            if (!CPHA) spi_mosi_o <= first_bit(data_i);
          end
        end
        SETUP: begin
          if (tmr == CNT_W'(CS_SETUP_CLKS - 1)) begin
            state    <= SHIFT;
            tmr      <= '0;
            half_cnt <= '0;
            edge_cnt <= '0;
          end else begin
            tmr <= tmr + CNT_W'(1);
          end
        end
        SHIFT: begin
          half_cnt <= half_end_c ? '0 : half_cnt + HALF_W'(1);
          if (pre_end_c && !last_q) data_ready_o <= 1'b1;
          if (half_end_c) begin
            spi_clk_o <= ~spi_clk_o;
            edge_cnt  <= edge_cnt + EDGE_W'(1);
            if (!edge_cnt[0]) begin
              // leading edge
              if (CPHA) begin
                spi_mosi_o <= first_bit(shreg);
                shreg      <= shift_out(shreg);
              end
            end else if (!word_end_c && !CPHA) begin
              // trailing edge other than the final one
              spi_mosi_o <= first_bit(shreg);
              shreg      <= shift_out(shreg);
            end
          end
          if (word_end_c) begin
            edge_cnt <= '0;
            if (accept_c) begin
              // back-to-back word: keep the clock running
              data_ready_o <= 1'b0;
              last_q       <= data_last_i;
              shreg        <= CPHA ? data_i : shift_out(data_i);
              if (!CPHA) spi_mosi_o <= first_bit(data_i);
            end else if (!last_q) begin
              state <= WAIT;
            end else begin
              state <= HOLD;
              tmr   <= '0;
            end
          end
        end
        WAIT: begin
          if (accept_c) begin
            state        <= SHIFT;
            data_ready_o <= 1'b0;
            half_cnt     <= '0;
            edge_cnt     <= '0;
            last_q       <= data_last_i;
            shreg        <= CPHA ? data_i : shift_out(data_i);
            if (!CPHA) spi_mosi_o <= first_bit(data_i);
          end
        end
        HOLD: begin
          if (tmr == CNT_W'(CS_HOLD_CLKS - 1)) begin
            state      <= GAP;
            tmr        <= '0;
            spi_cs_n_o <= 1'b1;
            spi_mosi_o <= 1'b0;
          end else begin
            tmr <= tmr + CNT_W'(1);
          end
        end
        GAP: begin
          if (tmr == CNT_W'(CS_IDLE_CLKS - 1)) begin
            state        <= IDLE;
            tmr          <= '0;
            busy_o       <= 1'b0;
            data_ready_o <= 1'b1;
          end else begin
            tmr <= tmr + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx_cs.sv
// Directed bench for spi_master_tx_cs: three instances cover mode 0 MSb-first,
// mode 3 LSb-first and a 16-bit word width.
module tb_spi_master_tx_cs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  d0, d1;
  logic [15:0] d2;
  logic        v[3];
  logic        l[3];
  logic        rdy[3], bsy[3], sclk[3], mosi[3], csn[3];

  int tests = 0;
  int fails = 0;

  spi_master_tx_cs #(.DATA_WIDTH(8), .SPI_MODE(0), .LSB_FIRST(0)) u0 (
    .clk_i(clk), .rst_i(rst_n), .data_i(d0), .data_valid_i(v[0]), .data_last_i(l[0]),
    .data_ready_o(rdy[0]), .busy_o(bsy[0]), .spi_clk_o(sclk[0]), .spi_mosi_o(mosi[0]),
    .spi_cs_n_o(csn[0]));

  spi_master_tx_cs #(.DATA_WIDTH(8), .SPI_MODE(3), .LSB_FIRST(1)) u1 (
    .clk_i(clk), .rst_i(rst_n), .data_i(d1), .data_valid_i(v[1]), .data_last_i(l[1]),
    .data_ready_o(rdy[1]), .busy_o(bsy[1]), .spi_clk_o(sclk[1]), .spi_mosi_o(mosi[1]),
    .spi_cs_n_o(csn[1]));

  spi_master_tx_cs #(.DATA_WIDTH(16), .SPI_MODE(0), .LSB_FIRST(0)) u2 (
    .clk_i(clk), .rst_i(rst_n), .data_i(d2), .data_valid_i(v[2]), .data_last_i(l[2]),
    .data_ready_o(rdy[2]), .busy_o(bsy[2]), .spi_clk_o(sclk[2]), .spi_mosi_o(mosi[2]),
    .spi_cs_n_o(csn[2]));

  // Serial monitor: MOSI captured on spi_clk rising edges, CS statistics
  logic        mon_clr = 1'b0;
  logic [31:0] bits[3];
  int          rises[3], cslow[3], csfall[3], first_rise_at[3], acc[3];
  logic        prev_sclk[3], prev_cs[3], sclk_last_low[3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mon_clr) begin
        bits[i] <= '0; rises[i] <= 0; cslow[i] <= 0; csfall[i] <= 0;
        first_rise_at[i] <= -1;
      end else begin
        if (!prev_sclk[i] && sclk[i]) begin
          if (rises[i] == 0) first_rise_at[i] <= cslow[i];
          rises[i] <= rises[i] + 1;
          bits[i]  <= {bits[i][30:0], mosi[i]};
        end
        if (!csn[i]) cslow[i] <= cslow[i] + 1;
        if (prev_cs[i] && !csn[i]) csfall[i] <= csfall[i] + 1;
        if (!prev_cs[i] && csn[i]) sclk_last_low[i] <= prev_sclk[i];
      end
      prev_sclk[i] <= sclk[i];
      prev_cs[i]   <= csn[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mon_clr) acc[i] <= 0;
      else if (v[i] && rdy[i]) acc[i] <= acc[i] + 1;
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    repeat (2) @(posedge clk);
    mon_clr = 1'b0;
    @(negedge clk);
  endtask

  // Present one word and hold it until the handshake completes
  task automatic send(input int d, input logic [15:0] data, input logic last);
    bit ok = 0;
    @(negedge clk);
    case (d)
      0: d0 = data[7:0];
      1: d1 = data[7:0];
      default: d2 = data;
    endcase
    v[d] = 1'b1; l[d] = last;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (rdy[d]) ok = 1;
      @(negedge clk);
    end
    v[d] = 1'b0; l[d] = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL send_timeout dut=%0d ready never seen", d); end
  endtask

  task automatic wait_idle(input int d);
    bit ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (!bsy[d]) ok = 1;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL idle_timeout dut=%0d busy stuck", d); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({csn[0], sclk[0], mosi[0], rdy[0], bsy[0]} !== 5'b10000) begin
      fails++; $display("FAIL reset_u0 got=%b exp=10000", {csn[0], sclk[0], mosi[0], rdy[0], bsy[0]});
    end
    tests++;
    if (sclk[1] !== 1'b1) begin fails++; $display("FAIL reset_cpol_u1 got=%b exp=1", sclk[1]); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (rdy[0] !== 1'b1) begin fails++; $display("FAIL ready_after_reset got=%b exp=1", rdy[0]); end
  endtask

  task automatic test_mode0_single();
    int gap = 0;
    int mosi_bad = 0;
    clear_mon();
    send(0, 16'h00A5, 1'b1);
    for (int i = 0; i < 200 && csn[0] == 1'b0; i++) @(negedge clk);
    while (csn[0] && !rdy[0] && gap < 20) begin
      gap++;
      if (mosi[0] !== 1'b0) mosi_bad++;
      @(negedge clk);
    end
    tests++;
    if (bits[0][7:0] !== 8'hA5) begin fails++; $display("FAIL m0_data got=%h exp=a5", bits[0][7:0]); end
    tests++;
    if (rises[0] != 8) begin fails++; $display("FAIL m0_rises got=%0d exp=8", rises[0]); end
    tests++;
    if (cslow[0] != 36) begin fails++; $display("FAIL m0_cs_low got=%0d exp=36", cslow[0]); end
    tests++;
    if (first_rise_at[0] != 4) begin fails++; $display("FAIL m0_setup got=%0d exp=4", first_rise_at[0]); end
    tests++;
    if (gap != 2 || mosi_bad != 0) begin
      fails++; $display("FAIL m0_gap got=%0d/%0d exp=2/0", gap, mosi_bad);
    end
    tests++;
    if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      fails++; $display("FAIL m0_idle ready=%b busy=%b exp 1/0", rdy[0], bsy[0]);
    end
  endtask

  task automatic test_mode3_lsb();
    clear_mon();
    send(1, 16'h0081, 1'b1);
    wait_idle(1);
    tests++;
    if (bits[1][7:0] !== 8'h81 || rises[1] != 8) begin
      fails++; $display("FAIL m3_81 got=%h/%0d exp=81/8", bits[1][7:0], rises[1]);
    end
    tests++;
    if (sclk_last_low[1] !== 1'b1 || sclk[1] !== 1'b1) begin
      fails++; $display("FAIL m3_clk_idle got=%b/%b exp=1/1", sclk_last_low[1], sclk[1]);
    end
    clear_mon();
    send(1, 16'h000D, 1'b1);
    wait_idle(1);
    tests++;
    if (bits[1][7:0] !== 8'hB0) begin fails++; $display("FAIL m3_order got=%h exp=b0", bits[1][7:0]); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send(0, 16'h0012, 1'b0);
    send(0, 16'h0034, 1'b1);
    wait_idle(0);
    tests++;
    if (bits[0][15:0] !== 16'h1234 || rises[0] != 16) begin
      fails++; $display("FAIL b2b_data got=%h/%0d exp=1234/16", bits[0][15:0], rises[0]);
    end
    tests++;
    if (csfall[0] != 1 || cslow[0] != 68) begin
      fails++; $display("FAIL b2b_cs got=%0d/%0d exp=1/68", csfall[0], cslow[0]);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    int guard = 0;
    clear_mon();
    send(0, 16'h0012, 1'b0);
    while (!rdy[0] && guard < 200) begin guard++; @(negedge clk); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (csn[0] !== 1'b0 || sclk[0] !== 1'b0 || rdy[0] !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0 || guard >= 200) begin fails++; $display("FAIL stall_wait bad=%0d exp=0", bad); end
    send(0, 16'h0034, 1'b1);
    wait_idle(0);
    tests++;
    if (bits[0][15:0] !== 16'h1234 || rises[0] != 16) begin
      fails++; $display("FAIL stall_data got=%h/%0d exp=1234/16", bits[0][15:0], rises[0]);
    end
    tests++;
    if (csfall[0] != 1 || cslow[0] != 79) begin
      fails++; $display("FAIL stall_cs got=%0d/%0d exp=1/79", csfall[0], cslow[0]);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    clear_mon();
    send(2, 16'h1234, 1'b1);
    while (rises[2] < 4 && guard < 200) begin guard++; @(negedge clk); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({csn[2], sclk[2], mosi[2], rdy[2], bsy[2]} !== 5'b10000 || guard >= 200) begin
      fails++; $display("FAIL reset_mid got=%b exp=10000", {csn[2], sclk[2], mosi[2], rdy[2], bsy[2]});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    send(2, 16'hBEEF, 1'b1);
    wait_idle(2);
    tests++;
    if (bits[2][15:0] !== 16'hBEEF || rises[2] != 16 || cslow[2] != 68) begin
      fails++; $display("FAIL reset_resume got=%h/%0d/%0d exp=beef/16/68", bits[2][15:0], rises[2], cslow[2]);
    end
  endtask

  task automatic test_valid_held();
    int bad = 0;
    clear_mon();
    d0 = 8'h5A; l[0] = 1'b1; v[0] = 1'b1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (bsy[0] !== !(csn[0] && rdy[0])) bad++;
    end
    v[0] = 1'b0; l[0] = 1'b0;
    wait_idle(0);
    tests++;
    if (acc[0] != 5 || csfall[0] != 5) begin
      fails++; $display("FAIL held_accepts got=%0d/%0d exp=5/5", acc[0], csfall[0]);
    end
    tests++;
    if (rises[0] != 40 || bits[0][7:0] !== 8'h5A) begin
      fails++; $display("FAIL held_data got=%0d/%h exp=40/5a", rises[0], bits[0][7:0]);
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL held_busy got=%0d exp=0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin v[i] = 1'b0; l[i] = 1'b0; end
    d0 = '0; d1 = '0; d2 = '0;
    test_reset();
    test_mode0_single();
    test_mode3_lsb();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_valid_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_tx_cs.md
Name: spi_master_tx_cs

Overview:
Parametrised transmit-only SPI master. It adds configurable word width, bit order, chip select with setup, hold and idle timing, and multi-word bursts under a single CS assertion. It sits between the wave-generator sample path and an external SPI DAC or peripheral. A valid/ready handshake replaces the fire-and-forget strobe.

Parameters:
DATA_WIDTH, 8, bits per word (>=2).
SPI_MODE, 0, 0..3; CPOL = mode[1], CPHA = mode[0].
CLKS_PER_HALF_BIT, 2, system clocks per spi_clk half period (>=2).
LSB_FIRST, 0, 0 = MSb first, 1 = LSb first.
CS_SETUP_CLKS, 2, cycles from CS falling to the first spi_clk edge period start (>=1).
CS_HOLD_CLKS, 2, cycles from the last spi_clk edge to CS rising (>=1).
CS_IDLE_CLKS, 2, minimum CS-high cycles between frames (>=1).

Ports:
clk_i  in  1  system clock.
rst_i  in  1  asynchronous active-low reset.
data_i  in  DATA_WIDTH  word to transmit.
data_valid_i  in  1  word valid.
data_last_i  in  1  word ends the CS frame; sampled with data_i.
data_ready_o  out  1  block accepts a word this cycle.
busy_o  out  1  high whenever state != IDLE.
spi_clk_o  out  1  SPI clock.
spi_mosi_o  out  1  SPI data out.
spi_cs_n_o  out  1  chip select, active low.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is asynchronous, active-low.
- Reset values: spi_clk_o = CPOL, spi_mosi_o = 0, spi_cs_n_o = 1, data_ready_o = 0, busy_o = 0. FSM goes to IDLE. All counters clear.
- Reset mid-transfer aborts immediately. Outputs take reset values on the asynchronous assert. No partial word resumes after release.
- First cycle after reset release: data_ready_o = 1.
- All outputs are registered. A word is accepted on a clk_i edge where data_valid_i & data_ready_o. data_i and data_last_i are latched into a shift register and a last flag at that edge.
- FSM states: IDLE, SETUP, SHIFT, WAIT, HOLD, GAP.
- IDLE: ready = 1, cs_n = 1. Accept -> SETUP, with cs_n = 0 from the next cycle.
- SETUP: lasts CS_SETUP_CLKS cycles. If CPHA = 0, MOSI presents the first bit from the SETUP entry cycle. Then -> SHIFT.
- SHIFT: half-bit counter runs 0..CLKS_PER_HALF_BIT-1. spi_clk toggles at each half-bit boundary.
  - Each word has 2*DATA_WIDTH edges; odd edges are leading, even edges are trailing.
  - CPHA = 0: MOSI advances on each trailing edge except the final one.
  - CPHA = 1: MOSI advances on each leading edge, including the first.
  - Bit order: index DATA_WIDTH-1 down to 0 (LSB_FIRST = 0), or 0 up to DATA_WIDTH-1 (LSB_FIRST = 1).
  - A word occupies exactly 2*DATA_WIDTH*CLKS_PER_HALF_BIT cycles in SHIFT.
- Word end with the last flag clear: ready = 1 in the final SHIFT cycle.
  - If a word is accepted there, it goes straight into SHIFT with no gap: continuous spi_clk, cs_n stays 0. For CPHA = 0, its first bit appears on MOSI on the same cycle as the final trailing edge.
  - Otherwise -> WAIT: ready = 1, cs_n = 0, spi_clk = CPOL, MOSI holds its value. Accept in WAIT -> SETUP-less SHIFT. For CPHA = 0, the first bit is presented on the accept+1 cycle, and the clock starts one half bit later.
- Word end with the last flag set -> HOLD for CS_HOLD_CLKS cycles, ready = 0, spi_clk = CPOL. Then cs_n = 1 and -> GAP.
- GAP: CS_IDLE_CLKS cycles, ready = 0, MOSI = 0. Then -> IDLE.
- data_ready_o is 0 in SETUP, in HOLD, in GAP, and in SHIFT except the final cycle.
- data_valid_i held while not ready: no acceptance and no state effect. Input data may change freely.
- spi_clk_o idles at CPOL in every state except SHIFT. It never glitches: one toggle per half-bit boundary.
- Counters are sized $clog2 of their maximum value. Bit index wraps only through reload at word accept.

Test Plan:
1. DATA_WIDTH = 8, mode 0, CLKS_PER_HALF_BIT = 2, send 0xA5 with last = 1 -> 8 rising edges. MOSI sampled on rising edges = 1,0,1,0,0,1,0,1. cs_n low for 2+32+2 cycles. Then 2 cycles of GAP before ready.
2. Mode 3, LSB_FIRST = 1, send 0x81 with last = 1 -> spi_clk idles high. MOSI sampled on rising edges = 1,0,0,0,0,0,0,1. spi_clk returns to 1 before cs_n rises.
3. Burst: 0x12 (last = 0) accepted, then 0x34 (last = 1) presented on the end-of-word ready cycle -> 16 contiguous clock periods and a single cs_n low pulse. Serial stream = 0x1234.
4. Burst with a 10-cycle stall between words -> WAIT entered. cs_n stays 0 and spi_clk stays at CPOL throughout. The second word is transmitted correctly.
5. Assert rst_i low at bit 4 of a 16-bit word (DATA_WIDTH = 16) -> immediate cs_n = 1, spi_clk = CPOL, MOSI = 0. After release, a fresh 0xBEEF is sent correctly.
6. Hold data_valid_i high continuously with last = 1 -> each word is separated by HOLD+GAP. No acceptance occurs outside ready cycles, and busy_o matches the state.
